// File: rtl/mio_bus_bridge_if.sv
// CPU-side, block-RAM and peripheral-bus signals of the memory/IO bridge.
// The bridge uses the master modport; the CPU/RAM/peripheral side uses slave.
interface mio_bus_if #(
  parameter int RAM_AW = 10
);
  logic              MemRead;
  logic              MemWrite;
  logic              CPU_MIO;
  logic [31:0]       addr;
  logic [31:0]       Data_out;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic [RAM_AW-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [31:0]       mem_dout;
  logic [31:0]       io_addr;
  logic [31:0]       io_din;
  logic              io_rd;
  logic              io_we;
  logic [31:0]       io_dout;
  logic              io_ack;
  logic              bus_err;

  modport master (
    input  MemRead, MemWrite, CPU_MIO, addr, Data_out, mem_dout, io_dout, io_ack,
    output Data_in, MIO_ready, mem_addr, mem_din, mem_we, io_addr, io_din,
           io_rd, io_we, bus_err
  );

  modport slave (
    output MemRead, MemWrite, CPU_MIO, addr, Data_out, mem_dout, io_dout, io_ack,
    input  Data_in, MIO_ready, mem_addr, mem_din, mem_we, io_addr, io_din,
           io_rd, io_we, bus_err
  );
endinterface

// File: rtl/mio_bus_bridge.sv
// Memory/IO bus bridge: routes ctrl requests to block RAM or the peripheral bus.
// Optional IO timeout abort is enabled with `define MIO_TIMEOUT_EN.
module mio_bus_bridge #(
  parameter int RAM_AW     = 10,
  parameter int RAM_WAIT   = 1,
  parameter int IO_TIMEOUT = 64
) (
  input logic       clk,
  input logic       reset,
  mio_bus_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RAM, S_IO, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_din;
  logic        r_is_write;
  logic        r_err;
  logic [3:0]  r_cnt;

  logic w_req;
  logic w_io_sel;
  logic w_timeout;
  logic w_mem_we;
  logic w_io_rd;
  logic w_io_we;
  logic w_ready;

  assign w_req    = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign w_io_sel = (bus.addr[31:29] == 3'b111);

`ifdef MIO_TIMEOUT_EN
  localparam int TMO_W = $clog2(IO_TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
  // Timeout fires in the IO_TIMEOUT-th strobe cycle when no ack has arrived.
  assign w_timeout = (r_tmo == TMO_W'(IO_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_mem_we = 1'b0;
    w_io_rd  = 1'b0;
    w_io_we  = 1'b0;
    w_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = w_io_sel ? S_IO : S_RAM;
      end
      S_RAM: begin
        // Counter still at its load value only in the first RAM cycle.
        w_mem_we = r_is_write && (r_cnt == 4'(RAM_WAIT));
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_IO: begin
        w_io_rd = ~r_is_write;
        w_io_we = r_is_write;
        if (bus.io_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_ready = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_din      <= '0;
      r_is_write <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
`ifdef MIO_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= bus.addr;
            r_wdata    <= bus.Data_out;
            r_is_write <= bus.MemWrite;
            r_cnt      <= 4'(RAM_WAIT);
`ifdef MIO_TIMEOUT_EN
            r_tmo      <= '0;
`endif
            if (bus.MemRead && bus.MemWrite) r_err <= 1'b1;
          end
        end
        S_RAM: begin
          if (r_cnt != 4'd0)    r_cnt <= r_cnt - 4'd1;
          else if (!r_is_write) r_din <= bus.mem_dout;
        end
        S_IO: begin
`ifdef MIO_TIMEOUT_EN
          if (!w_timeout) r_tmo <= r_tmo + TMO_W'(1);
`endif
          if (bus.io_ack) begin
            if (!r_is_write) r_din <= bus.io_dout;
          end else if (w_timeout) begin
            if (!r_is_write) r_din <= 32'hDEAD_BEEF;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Data_in   = r_din;
  assign bus.MIO_ready = w_ready;
  assign bus.mem_addr  = r_addr[RAM_AW+1:2];
  assign bus.mem_din   = r_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.io_addr   = r_addr;
  assign bus.io_din    = r_wdata;
  assign bus.io_rd     = w_io_rd;
  assign bus.io_we     = w_io_we;
  assign bus.bus_err   = r_err;

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Bench for mio_bus_bridge: directed and random accesses against a transaction-level model.
module tb_mio_bus_bridge;
  localparam int RW  = 3;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset;
  int   errs   = 0;
  int   checks = 0;

  mio_bus_if #(.RAM_AW(10)) bus ();

  mio_bus_bridge #(.RAM_AW(10), .RAM_WAIT(RW), .IO_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment block RAM, 1-cycle synchronous read
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  // Reference model state
  logic [31:0] shadow [0:1023];
  logic [31:0] exp_din;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CPU_MIO  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.io_ack   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_din = 32'h0;
    exp_err = 1'b0;
  endtask

  // One complete access; ackdly<0 means the peripheral never acknowledges.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int ackdly, input logic [31:0] iod);
    int cyc, ready_cyc, nready, nwe, nstb, exp_lat, exp_stb;
    logic is_io;
    is_io = (a[31:28] == 4'hE) || (a[31:28] == 4'hF);
    bus.CPU_MIO  = 1'b1;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.addr     = a;
    bus.Data_out = d;
    bus.io_dout  = iod;
    bus.io_ack   = 1'b0;
    ready_cyc = -1; nready = 0; nwe = 0; nstb = 0; cyc = 0;
    while ((ready_cyc < 0 || cyc <= ready_cyc) && cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        bus.CPU_MIO  = 1'b0;
        bus.addr     = $urandom;
        bus.Data_out = $urandom;
        bus.MemRead  = 1'($urandom);
        bus.MemWrite = 1'($urandom);
      end
      if (bus.mem_we) begin
        nwe++;
        chk("mem_addr", 32'(bus.mem_addr), 32'(a[11:2]));
        chk("mem_din", bus.mem_din, d);
      end
      if (bus.io_rd || bus.io_we) begin
        nstb++;
        if (nstb == 1) begin
          chk("io_addr", bus.io_addr, a);
          chk("io_rd", 32'(bus.io_rd), 32'(!wr));
          if (wr) chk("io_din", bus.io_din, d);
        end
        bus.io_ack = (ackdly >= 0) && (nstb == ackdly + 1);
      end else begin
        bus.io_ack = 1'b0;
      end
      if (bus.MIO_ready) begin
        nready++;
        if (ready_cyc < 0) ready_cyc = cyc;
      end
    end
    bus.io_ack = 1'b0;

    if (rd && wr) exp_err = 1'b1;
    if (!is_io) begin
      exp_lat = 2 + RW;
      exp_stb = 0;
      if (wr) shadow[a[11:2]] = d;
      else    exp_din = shadow[a[11:2]];
    end else if (ackdly >= 0) begin
      exp_lat = ackdly + 2;
      exp_stb = ackdly + 1;
      if (!wr) exp_din = iod;
    end else begin
      exp_lat = TMO + 1;
      exp_stb = TMO;
      if (!wr) exp_din = 32'hDEAD_BEEF;
      exp_err = 1'b1;
    end
    chk("ready_cycle", 32'(ready_cyc), 32'(exp_lat));
    chk("ready_pulses", 32'(nready), 32'd1);
    chk("mem_we_pulses", 32'(nwe), (!is_io && wr) ? 32'd1 : 32'd0);
    chk("io_strobe_cycles", 32'(nstb), 32'(exp_stb));
    chk("Data_in", bus.Data_in, exp_din);
    chk("bus_err", 32'(bus.bus_err), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_MIO_ready"}, 32'(bus.MIO_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_io_rd"}, 32'(bus.io_rd), 32'd0);
    chk({tag, "_io_we"}, 32'(bus.io_we), 32'd0);
    chk({tag, "_Data_in"}, bus.Data_in, 32'd0);
    chk({tag, "_bus_err"}, 32'(bus.bus_err), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, v;
    int n_bad;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ram[i] = v;
      shadow[i] = v;
    end
    ram[4]    = 32'h3C03_F000;
    shadow[4] = 32'h3C03_F000;
    bus.addr = '0; bus.Data_out = '0; bus.io_dout = '0;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b1;
    exp_din = 32'h0;
    exp_err = 1'b0;
    tick();

    // Directed accesses
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0);
    chk("ram_word4", bus.Data_in, 32'h3C03_F000);
    txn(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 0, 32'h0);
    txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h0);
    txn(1'b1, 1'b0, 32'hE000_0000, 32'h0, 3, 32'h0000_00AA);
    chk("io_read_AA", bus.Data_in, 32'h0000_00AA);
    txn(1'b0, 1'b1, 32'hF123_4568, 32'hCAFE_0001, 0, 32'h5555_5555);
    txn(1'b1, 1'b0, 32'hEFFF_FFFC, 32'h0, 0, 32'h0BAD_F00D);
    txn(1'b1, 1'b0, 32'hDFFF_FFFC, 32'h0, 0, 32'h0);

    // Random accesses
    for (int t = 0; t < 40; t++) begin
      logic wr;
      wr = 1'($urandom);
      d  = $urandom;
      if ($urandom_range(2) == 0) a = {3'b111, 29'($urandom)};
      else a = {4'($urandom_range(13)), 28'($urandom)};
      txn(!wr, wr, a, d, $urandom_range(5), $urandom);
    end

    // Reset in the middle of a RAM write
    bus.CPU_MIO = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b1;
    bus.addr = 32'h0000_0100; bus.Data_out = 32'hA5A5_0F0F;
    tick();
    idle_inputs();
    shadow[64] = 32'hA5A5_0F0F;
    tick();
    reset = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    reset = 1'b1;
    exp_din = 32'h0;
    exp_err = 1'b0;
    n_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.mem_we || bus.MIO_ready) n_bad++;
    end
    chk("post_reset_activity", 32'(n_bad), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0);

    // Read and write together: write wins, sticky error
    txn(1'b1, 1'b1, 32'h0000_0000, 32'h7777_1111, 0, 32'h0);
    txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h0);
    txn(1'b1, 1'b0, 32'hE000_0040, 32'h0, 1, 32'h0000_0042);
    do_reset();
    chk("err_cleared", 32'(bus.bus_err), 32'd0);

`ifdef MIO_TIMEOUT_EN
    txn(1'b1, 1'b0, 32'hF000_0004, 32'h0, -1, 32'h0);
    chk("timeout_data", bus.Data_in, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'hE000_0008, 32'h1, -1, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
